// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between the I-cache refill path and the
// D-cache refill/write-back path. It grants one requester at a time and runs a
// BURST_LEN-beat line burst at line-aligned, incrementing word addresses.
// Optional feature: define ROUND_ROBIN_EN to alternate grants on simultaneous
// requests. Without it, D always wins over I.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      i_req_i,
    input  logic [ADDR_WIDTH-1:0]                     i_addr_i,
    output logic                                      i_ready_o,
    output logic                                      i_done_o,
    output logic [DATA_WIDTH-1:0]                     i_rdata_o,
    input  logic                                      d_req_i,
    input  logic                                      d_we_i,
    input  logic [ADDR_WIDTH-1:0]                     d_addr_i,
    input  logic [DATA_WIDTH-1:0]                     d_wdata_i,
    output logic                                      d_ready_o,
    output logic                                      d_done_o,
    output logic [DATA_WIDTH-1:0]                     d_rdata_o,
    output logic [(BURST_LEN > 1 ? $clog2(BURST_LEN) : 1)-1:0] beat_o,
    output logic                                      mem_req_o,
    output logic                                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]                     mem_addr_o,
    output logic [DATA_WIDTH-1:0]                     mem_wdata_o,
    input  logic                                      mem_ready_i,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata_i
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // Byte offset bits covered by one line (word index bits plus the 2 byte bits).
    localparam int unsigned OffW  = $clog2(BURST_LEN) + 2;
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        ~((ADDR_WIDTH'(1) << OffW) - ADDR_WIDTH'(1));
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StIBurst, StDBurst} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    we_q, we_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic                    last_beat;
    logic                    grant_d_sel;

    assign last_beat = (beat_q == LastBeat);

`ifdef ROUND_ROBIN_EN
    // 1 = D was served last, 0 = I was served last.
    logic last_grant_q, last_grant_d;

    // On a tie, grant the requester that was not served last.
    always_comb grant_d_sel = d_req_i && (!i_req_i || !last_grant_q);

    // Remember who was granted so the next tie goes the other way.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && (d_req_i || i_req_i)) begin
            last_grant_d = grant_d_sel;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: D always wins.
    always_comb grant_d_sel = d_req_i;
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant from idle, return to idle after the last beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d_sel) begin
                    state_d = StDBurst;
                end else if (i_req_i) begin
                    state_d = StIBurst;
                end
            end
            StIBurst, StDBurst: begin
                if (mem_ready_i && last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst datapath next state: latch line base and direction at grant, step beats.
    always_comb begin
        base_d = base_q;
        we_d   = we_q;
        beat_d = beat_q;
        if (state_q == StIdle) begin
            beat_d = '0;
            if (grant_d_sel) begin
                base_d = d_addr_i & LineMask;
                we_d   = d_we_i;
            end else if (i_req_i) begin
                base_d = i_addr_i & LineMask;
                we_d   = 1'b0;
            end
        end else if (mem_ready_i) begin
            // Beat wraps to 0 on the last beat; BURST_LEN = 1 keeps it at 0.
            beat_d = last_beat ? '0 : beat_q + BeatW'(1);
        end
    end

    // Burst datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q <= '0;
            we_q   <= 1'b0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            we_q   <= we_d;
            beat_q <= beat_d;
        end
    end

    // Outputs: drive memory from the latched burst and route the handshake to the grantee.
    always_comb begin
        i_ready_o   = 1'b0;
        i_done_o    = 1'b0;
        i_rdata_o   = '0;
        d_ready_o   = 1'b0;
        d_done_o    = 1'b0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        beat_o      = beat_q;
        unique case (state_q)
            StIBurst: begin
                mem_req_o  = 1'b1;
                mem_we_o   = we_q;
                // base has the offset bits clear, so OR never carries into the line.
                mem_addr_o = base_q | (ADDR_WIDTH'(beat_q) << 2);
                i_ready_o  = mem_ready_i;
                i_done_o   = mem_ready_i && last_beat;
                i_rdata_o  = mem_rdata_i;
            end
            StDBurst: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = base_q | (ADDR_WIDTH'(beat_q) << 2);
                mem_wdata_o = d_wdata_i;
                d_ready_o   = mem_ready_i;
                d_done_o    = mem_ready_i && last_beat;
                d_rdata_o   = mem_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized line bursts for mem_arbiter, checked against
// a transaction-level model (arbitration rule, line base, beat addresses, handshakes).
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;
    localparam logic [31:0] LINE_MASK = ~(32'(BL * 4) - 32'd1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_ready_o;
    logic          i_done_o;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_ready_o;
    logic          d_done_o;
    logic [DW-1:0] d_rdata_o;
    logic [1:0]    beat_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic [DW-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    bit lg_is_d;  // model: last served requester was D

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_ready_o  (i_ready_o),
        .i_done_o   (i_done_o),
        .i_rdata_o  (i_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ready_o  (d_ready_o),
        .d_done_o   (d_done_o),
        .d_rdata_o  (d_rdata_o),
        .beat_o     (beat_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: D wins unless round robin is on and D was served last.
    function automatic bit pick_d(input bit ireq, input bit dreq);
        bit rr = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr = 1'b1;
`endif
        if (rr && ireq && dreq) return !lg_is_d;
        return dreq;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req_o), 0);
        check({tag, "_mem_we"}, 32'(mem_we_o), 0);
        check({tag, "_i_ready"}, 32'(i_ready_o), 0);
        check({tag, "_d_ready"}, 32'(d_ready_o), 0);
        check({tag, "_i_done"}, 32'(i_done_o), 0);
        check({tag, "_d_done"}, 32'(d_done_o), 0);
    endtask

    // Serve one granted line; starts in the idle cycle before the burst, returns in the
    // done cycle. abort_b >= 0 asserts reset at the start of that beat instead.
    task automatic burst(input bit gd, input bit we, input logic [31:0] base,
                         input int minw, input int maxw, input int abort_b);
        for (int b = 0; b < int'(BL); b++) begin
            int w;
            w = int'($urandom_range(maxw, minw));
            for (int k = 0; k <= w; k++) begin
                logic        rdy;
                logic [31:0] rd;
                @(negedge clk);
                if (b == abort_b) begin
                    rst_i = 1'b1;
                    mem_ready_i = 1'b0;
                    #1;
                    check("abort_done", 32'(gd ? d_done_o : i_done_o), 0);
                    return;
                end
                rdy = (k == w);
                rd = $urandom;
                mem_ready_i = rdy;
                mem_rdata_i = rd;
                d_wdata_i = 32'hA0 + 32'(b);
                #1;
                check("mem_req", 32'(mem_req_o), 1);
                check("mem_we", 32'(mem_we_o), 32'(we));
                check("mem_addr", mem_addr_o, base + 32'(b * 4));
                check("beat", 32'(beat_o), 32'(b));
                check("mem_wdata", mem_wdata_o, gd ? 32'hA0 + 32'(b) : 32'h0);
                if (gd) begin
                    check("d_ready", 32'(d_ready_o), 32'(rdy));
                    check("d_done", 32'(d_done_o), 32'(rdy && b == int'(BL) - 1));
                    check("i_ready_ungranted", 32'(i_ready_o), 0);
                    check("i_done_ungranted", 32'(i_done_o), 0);
                    check("i_rdata_ungranted", i_rdata_o, 0);
                    if (rdy) check("d_rdata", d_rdata_o, rd);
                end else begin
                    check("i_ready", 32'(i_ready_o), 32'(rdy));
                    check("i_done", 32'(i_done_o), 32'(rdy && b == int'(BL) - 1));
                    check("d_ready_ungranted", 32'(d_ready_o), 0);
                    check("d_done_ungranted", 32'(d_done_o), 0);
                    check("d_rdata_ungranted", d_rdata_o, 0);
                    if (rdy) check("i_rdata", i_rdata_o, rd);
                end
            end
        end
    endtask

    // Raise requests for ni I-lines and nd D-lines and serve them in model order.
    task automatic serve_round(input int ni_in, input int nd_in, input logic [31:0] ia,
                               input logic [31:0] da, input bit we, input int minw,
                               input int maxw);
        int ni;
        int nd;
        bit gd;
        ni = ni_in;
        nd = nd_in;
        @(negedge clk);
        i_req_i = (ni > 0);
        d_req_i = (nd > 0);
        i_addr_i = ia;
        d_addr_i = da;
        d_we_i = we;
        mem_ready_i = 1'b0;
        #1;
        check_idle("req_cycle");
        check("req_cycle_beat", 32'(beat_o), 0);
        while (ni > 0 || nd > 0) begin
            gd = pick_d(ni > 0, nd > 0);
            lg_is_d = gd;
            burst(gd, gd ? we : 1'b0, (gd ? d_addr_i : i_addr_i) & LINE_MASK, minw, maxw, -1);
            if (gd) nd--; else ni--;
            @(negedge clk);
            mem_ready_i = 1'b0;
            i_req_i = (ni > 0);
            d_req_i = (nd > 0);
            if (gd) d_addr_i = $urandom; else i_addr_i = $urandom;
            #1;
            check_idle("dead_cycle");
        end
    endtask

    initial begin
        rst_i = 1'b1;
        i_req_i = 1'b0;
        i_addr_i = '0;
        d_req_i = 1'b0;
        d_we_i = 1'b0;
        d_addr_i = '0;
        d_wdata_i = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        lg_is_d = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        check("reset_addr", mem_addr_o, 0);
        check("reset_wdata", mem_wdata_o, 0);
        check("reset_beat", 32'(beat_o), 0);
        check("reset_i_rdata", i_rdata_o, 0);
        check("reset_d_rdata", d_rdata_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // I-only refill, memory ready every cycle: 0x1230..0x123C.
        serve_round(1, 0, 32'h0000_1234, 32'h0, 1'b0, 0, 0);
        // D write-back at 0x40 with wdata 0xA0+beat.
        serve_round(0, 1, 32'h0, 32'h0000_0040, 1'b1, 0, 0);
        // Simultaneous requests.
        serve_round(1, 1, 32'h0000_0800, 32'h0000_0C14, 1'b0, 0, 0);
        // Both held for two lines each.
        serve_round(2, 2, 32'h0000_3000, 32'h0000_4008, 1'b1, 0, 1);
        // Three wait states before every beat.
        serve_round(1, 0, 32'h0000_5678, 32'h0, 1'b0, 3, 3);
        serve_round(0, 1, 32'h0, 32'h0000_9ABC, 1'b1, 3, 3);

        // Reset at beat 2 of a D refill aborts it.
        @(negedge clk);
        d_req_i = 1'b1;
        d_we_i = 1'b0;
        d_addr_i = 32'h0000_2468;
        #1;
        lg_is_d = 1'b1;
        burst(1'b1, 1'b0, 32'h0000_2460, 0, 0, 2);
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req_o), 0);
        check("abort_d_done_after", 32'(d_done_o), 0);
        check("abort_d_ready", 32'(d_ready_o), 0);
        check("abort_beat", 32'(beat_o), 0);
        lg_is_d = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        serve_round(1, 0, 32'h0000_1F0C, 32'h0, 1'b0, 0, 2);

        // Randomized rounds.
        repeat (25) begin
            serve_round(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), $urandom,
                        $urandom, 1'($urandom_range(1, 0)), 0, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so a stuck bench still reports.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
